// File: rtl/rx.sv
// rx: serial-to-parallel flit receiver at the downstream end of a
// router-to-router serial link. It waits for a start bit, shifts in SIZE
// data bits LSB first, then holds the flit for the input buffer until it
// is acknowledged. channel_busy tells the transmitter when a new flit may
// begin.

`ifndef SIZE
`define SIZE 8
`endif

module rx #(
   parameter int    routerid = -1,
   parameter string port     = "unknown"
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               serial_in,
   output logic               channel_busy,
   output logic [`SIZE-1:0]   parallel_out,
   output logic               out_req,
   input  logic               out_ack,
   output logic               rx_active,
   output logic               overrun
);

   localparam int CW = (`SIZE > 1) ? $clog2(`SIZE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RECV = 2'd1;
   localparam logic [1:0] FULL = 2'd2;

   localparam logic [CW-1:0] LAST_BIT = CW'(`SIZE - 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [`SIZE-1:0] shift_reg;
   logic [`SIZE-1:0] word_next;

   // Busy whenever a flit is arriving or still waiting for the consumer.
   assign rx_active    = (state == RECV);
   assign out_req      = (state == FULL);
   assign channel_busy = rx_active | out_req;

   // Partial word with the bit being sampled on this edge merged in.
   always_comb begin
      word_next        = shift_reg;
      word_next[count] = serial_in;
   end

   // Receive state machine. The word is assembled in shift_reg and copied
   // to parallel_out only when complete, so parallel_out never shows a
   // partial flit. The ack edge out of FULL ignores serial_in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count        <= '0;
         shift_reg    <= '0;
         parallel_out <= '0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (serial_in) begin
                  state     <= RECV;
                  count     <= '0;
                  shift_reg <= '0;
               end
            end
            RECV: begin
               shift_reg <= word_next;
               if (count == LAST_BIT) begin
                  parallel_out <= word_next;
                  count        <= '0;
                  state        <= FULL;
               end else begin
                  count <= count + 1'b1;
               end
            end
            FULL: begin
               if (out_ack) begin
                  state <= IDLE;
               end else if (serial_in) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx.sv
// tb_rx: scoreboard bench for the rx flit receiver. Each transmitted flit
// pushes its expected value; a monitor pops and compares whenever out_req
// rises. Timing and handshake behaviour are checked inline.

`ifndef SIZE
`define SIZE 8
`endif

module tb_rx;

   logic             clk;
   logic             reset;
   logic             serial_in;
   logic             channel_busy;
   logic [`SIZE-1:0] parallel_out;
   logic             out_req;
   logic             out_ack;
   logic             rx_active;
   logic             overrun;

   int               vectors;
   int               miscompares;
   int               overrun_seen;
   logic             out_req_prev;
   logic [`SIZE-1:0] expected_q[$];

   rx #(.routerid(-1), .port("east")) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .channel_busy (channel_busy),
      .parallel_out (parallel_out),
      .out_req      (out_req),
      .out_ack      (out_ack),
      .rx_active    (rx_active),
      .overrun      (overrun)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: every new flit presented is checked against the scoreboard.
   always @(negedge clk) begin
      if (out_req && !out_req_prev) begin
         if (expected_q.size() == 0) begin
            check_output("unexpected_flit", 32'(parallel_out), 32'hDEAD);
         end else begin
            check_output("flit_data", 32'(parallel_out), 32'(expected_q.pop_front()));
         end
      end
      out_req_prev <= out_req;
      if (overrun) overrun_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check_output({name, "_busy"},   32'(channel_busy), 32'd0);
      check_output({name, "_data"},   32'(parallel_out), 32'd0);
      check_output({name, "_req"},    32'(out_req),      32'd0);
      check_output({name, "_active"}, 32'(rx_active),    32'd0);
      check_output({name, "_ovr"},    32'(overrun),      32'd0);
   endtask

   // Drive start bit plus SIZE data bits; caller is just after a posedge.
   task automatic apply_stimulus(input logic [`SIZE-1:0] data);
      expected_q.push_back(data);
      serial_in = 1'b1;
      for (int i = 0; i < `SIZE; i++) begin
         tick();
         check_output("rx_active_during_recv", 32'(rx_active), 32'd1);
         serial_in = data[i];
      end
      tick();
      serial_in = 1'b0;
      check_output("out_req_latency", 32'(out_req), 32'd1);
      check_output("rx_active_after_recv", 32'(rx_active), 32'd0);
   endtask

   task automatic ack_flit();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check_output("req_after_ack", 32'(out_req), 32'd0);
      check_output("busy_after_ack", 32'(channel_busy), 32'd0);
   endtask

   // Transmitter model: wait (bounded) for the link to be free, then send.
   task automatic tx_send(input logic [`SIZE-1:0] data);
      int waited = 0;
      while (channel_busy && waited < 200) begin
         tick();
         waited++;
      end
      check_output("tx_start_busy_low", 32'(channel_busy), 32'd0);
      apply_stimulus(data);
   endtask

   // Consumer model: ack 5 cycles after out_req, bounded wait.
   task automatic consume_one();
      int waited = 0;
      while (!out_req && waited < 200) begin
         tick();
         waited++;
      end
      check_output("consumer_saw_req", 32'(out_req), 32'd1);
      repeat (5) tick();
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
   endtask

   initial begin
      logic stable_ok;
      logic [`SIZE-1:0] partial;

      vectors      = 0;
      miscompares  = 0;
      overrun_seen = 0;
      out_req_prev = 1'b0;
      reset        = 1'b0;
      serial_in    = 1'b0;
      out_ack      = 1'b0;

      // Reset held with serial_in toggling.
      for (int i = 0; i < 3; i++) begin
         serial_in = ~serial_in;
         tick();
         check_idle("in_reset");
      end
      serial_in = 1'b0;
      reset     = 1'b1;
      repeat (3) tick();
      check_idle("after_reset");

      // Single flit, then ack.
      apply_stimulus(8'hA5);
      tick();
      check_output("hold_a5", 32'(parallel_out), 32'hA5);
      ack_flit();

      // All-zero and all-one flits.
      tick();
      apply_stimulus(8'h00);
      ack_flit();
      tick();
      apply_stimulus(8'hFF);
      ack_flit();
      tick();
      check_output("ff_no_restart", 32'(rx_active), 32'd0);

      // Back-pressure: hold 20 cycles, then one overrun bit.
      apply_stimulus(8'h3C);
      stable_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!channel_busy || parallel_out !== 8'h3C || overrun) stable_ok = 1'b0;
      end
      check_output("backpressure_stable", 32'(stable_ok), 32'd1);
      serial_in = 1'b1;
      tick();
      serial_in = 1'b0;
      check_output("overrun_pulse", 32'(overrun), 32'd1);
      tick();
      check_output("overrun_one_cycle", 32'(overrun), 32'd0);
      check_output("data_after_overrun", 32'(parallel_out), 32'h3C);
      check_output("req_after_overrun", 32'(out_req), 32'd1);
      ack_flit();

      // End-to-end with transmitter and delayed consumer.
      fork
         begin
            tx_send(8'h12);
            tx_send(8'h34);
         end
         begin
            consume_one();
            consume_one();
         end
      join
      tick();
      check_output("overrun_total", 32'(overrun_seen), 32'd1);

      // Reset in the middle of receiving 0x5A.
      tick();
      partial   = 8'h5A;
      serial_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         serial_in = partial[i];
      end
      tick();
      reset = 1'b0;
      #1;
      check_idle("mid_recv_reset");
      serial_in = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      tick();
      apply_stimulus(8'h81);
      ack_flit();

      repeat (2) tick();
      check_output("scoreboard_empty", 32'(expected_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
